tt_um_asiclab_sum_tx: RTL and testbench
=======================================

TT_UM_ASICLAB_SUM_TX -- requirements
Module: tt_um_asiclab_sum_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ui_in, input, 8 bits: [7:4] = operand A, [3:0] = operand B, both unsigned.
REQ-004 SHALL have port uio_in, input, 8 bits: [0] = start; [7:4] = DIV, baud divisor (clocks per bit = DIV+1); [3:1] unused.
REQ-005 SHALL have port ena, input, 1 bit: ignored.
REQ-006 SHALL have port uo_out, output, 8 bits: [0] = txd; [1] = busy; [2] = done; [7:3] = last captured sum.
REQ-007 SHALL have port uio_out, output, 8 bits: constant 0.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 0 (all uio pins are inputs).

Function
REQ-009 Start detection SHALL be a rising edge: start=1 while the registered copy start_q=0; start_q SHALL update every cycle, including while busy.
REQ-010 On a start edge in IDLE, the block SHALL, at the same clock edge:
  - capture SUM = A + B as 5 bits with carry into bit 4;
  - capture DIV;
  - drive uo_out[7:3] = SUM;
  - enter START with txd = 0 and busy = 1.
REQ-011 Start edges outside IDLE SHALL be ignored; captured SUM and DIV SHALL hold for the whole frame.
REQ-012 Frame SHALL be 8 bit-times: start (0), SUM[0]..SUM[4] LSB first, parity, stop (1).
REQ-013 Parity SHALL be even parity: XOR of SUM[4:0].
REQ-014 Each bit-time SHALL last exactly DIV+1 clocks, counted by a 4-bit down-counter reloaded with DIV at every bit boundary.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 FSM transitions SHALL occur only when the bit counter reaches 0:
  - START -> DATA;
  - DATA -> DATA until bit index 4 is sent, then -> PARITY;
  - PARITY -> STOP;
  - STOP -> IDLE.
REQ-017 A 3-bit bit index SHALL count DATA bits 0..4 and SHALL be cleared on entry to DATA.
REQ-018 Leaving STOP SHALL set busy = 0 and pulse done = 1 for exactly one cycle.
REQ-019 A new frame SHALL be able to begin on the first cycle after return to IDLE if a fresh start edge occurs.
REQ-020 Start edge to done pulse SHALL take exactly 8*(DIV+1) clocks, with busy high throughout.
REQ-021 In IDLE, txd SHALL be 1.
REQ-022 uo_out[7:3] SHALL hold the last SUM until the next accepted start.
REQ-023 txd SHALL be driven from a flop (no combinational glitches).

Reset
REQ-024 While rst_n = 0, the block SHALL force:
  - state = IDLE;
  - txd = 1, busy = 0, done = 0;
  - uo_out[7:3] = 0;
  - start_q = 0;
  - bit counter and bit index = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with no done pulse.
REQ-026 After release, a start level already high SHALL count as a start edge.

Structure
REQ-027 Package tt_sum_tx_pkg SHALL hold:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - FRAME_BITS = 8;
  - DATA_BITS = 5.
REQ-028 The baud counter SHALL be one sub-module, sum_tx_baud: loads DIV, emits a bit_end tick.
REQ-029 The FSM and shift register SHALL stay in the top.

Verification
REQ-030 A=9, B=8, DIV=0, start edge:
  - uo_out[7:3] = 17;
  - txd = 0,1,0,0,0,1,0,1 on consecutive cycles;
  - done pulses at cycle 8;
  - busy high for cycles 1-8.
REQ-031 A=15, B=15, DIV=3:
  - SUM = 30 (carry set), parity 0;
  - each bit 4 clocks, txd = 0,0,1,1,1,1,0,1 per bit-time;
  - done 32 clocks after start.
REQ-032 A=1, B=0, DIV=15: parity bit = 1; each bit lasts 16 clocks; total 128 clocks.
REQ-033 start held high across two frames' worth of time: exactly one frame, one done pulse. A second start edge mid-frame: no effect on txd and no change to uo_out[7:3].
REQ-034 rst_n low during DATA bit 2:
  - txd = 1, busy = 0, uo_out = 8'h01 immediately;
  - no done pulse;
  - the next start edge sends a full correct frame.
REQ-035 Back-to-back: a start edge in the cycle after done starts a new frame with the new operands, and txd goes low one cycle after done.

Source files
------------

// File: rtl/tt_um_asiclab_sum_tx_pkg.sv
// Shared types and constants for the sum-and-transmit block.
//   state_t    : FSM state encoding (IDLE..STOP, 3 bits)
//   FRAME_BITS : bit-times per serial frame (start + data + parity + stop)
//   DATA_BITS  : width of the transmitted sum
//   IDX_W      : width of the data-bit index counter
package tt_sum_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int FRAME_BITS = 8;
  localparam int DATA_BITS  = 5;
  localparam int IDX_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/tt_um_asiclab_sum_tx_baud.sv
// Bit-time counter: a 4-bit down-counter that is loaded when a frame is
// accepted and reloaded at every bit boundary, so each bit lasts DIV+1 clocks.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_div (frame accepted this cycle)
//   i_run       : frame in progress; counter runs and may tick
//   i_div       : divisor to load/reload
//   o_bit_end   : high in the last clock of the current bit-time
module sum_tx_baud (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [3:0] i_div,
  output logic       o_bit_end
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (i_load)  r_cnt <= i_div;
    else if (i_run)   r_cnt <= (r_cnt == 4'd0) ? i_div : r_cnt - 4'd1;
  end

  assign o_bit_end = i_run && (r_cnt == 4'd0);

endmodule

// File: rtl/tt_um_asiclab_sum_tx.sv
// Adds two 4-bit operands on a start edge and sends the 5-bit sum as a
// serial frame: start(0), SUM[0..4] LSB first, even parity, stop(1).
//   clk, rst_n : clock, async active-low reset
//   ui_in      : [7:4] operand A, [3:0] operand B
//   uio_in     : [0] start, [7:4] DIV (clocks per bit = DIV+1)
//   ena        : ignored
//   uo_out     : [0] txd, [1] busy, [2] done, [7:3] last captured sum
//   uio_out    : constant 0
//   uio_oe     : constant 0 (all uio pins are inputs)
module tt_um_asiclab_sum_tx
  import tt_sum_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  input  logic       ena,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t             r_state, w_state_n;
  logic               r_start_q, r_txd, w_txd_n, r_done, w_done_n;
  logic [4:0]         r_sum, r_shift, w_shift_n, w_sum;
  logic [3:0]         r_div;
  logic [IDX_W-1:0]   r_idx, w_idx_n;
  logic               w_start_edge, w_accept, w_bit_end, w_busy;

  assign w_start_edge = uio_in[0] && !r_start_q;
  assign w_accept     = (r_state == S_IDLE) && w_start_edge;
  assign w_busy       = (r_state != S_IDLE);
  assign w_sum        = {1'b0, ui_in[7:4]} + {1'b0, ui_in[3:0]};

  // On the accept cycle the baud counter must see the live DIV, since r_div
  // is only written at that same edge.
  sum_tx_baud u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_run     (w_busy),
    .i_div     (w_accept ? uio_in[7:4] : r_div),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_shift   <= '0;
      r_div     <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_start_q <= uio_in[0];
      r_txd     <= w_txd_n;
      r_done    <= w_done_n;
      r_shift   <= w_shift_n;
      r_idx     <= w_idx_n;
      if (w_accept) begin
        r_sum <= w_sum;
        r_div <= uio_in[7:4];
      end
    end
  end

  // txd is computed one cycle ahead and registered, so the line only ever
  // changes on a clock edge.
  always_comb begin
    w_state_n = r_state;
    w_txd_n   = r_txd;
    w_done_n  = 1'b0;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    unique case (r_state)
      S_IDLE: begin
        w_txd_n = 1'b1;
        if (w_start_edge) begin
          w_state_n = S_START;
          w_txd_n   = 1'b0;
          w_shift_n = w_sum;
        end
      end
      S_START: if (w_bit_end) begin
        w_state_n = S_DATA;
        w_idx_n   = '0;
        w_txd_n   = r_shift[0];
      end
      S_DATA: if (w_bit_end) begin
        if (r_idx == IDX_W'(DATA_BITS - 1)) begin
          w_state_n = S_PARITY;
          w_txd_n   = ^r_sum;
        end else begin
          w_idx_n   = r_idx + 1'b1;
          w_shift_n = r_shift >> 1;
          w_txd_n   = r_shift[1];
        end
      end
      S_PARITY: if (w_bit_end) begin
        w_state_n = S_STOP;
        w_txd_n   = 1'b1;
      end
      S_STOP: if (w_bit_end) begin
        w_state_n = S_IDLE;
        w_txd_n   = 1'b1;
        w_done_n  = 1'b1;
      end
      default: begin
        w_state_n = S_IDLE;
        w_txd_n   = 1'b1;
      end
    endcase
  end

  assign uo_out  = {r_sum, r_done, w_busy, r_txd};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic w_unused;
  assign w_unused = &{1'b0, ena, uio_in[3:1]};

endmodule

// File: tb/tb_tt_um_asiclab_sum_tx.sv
module tb_tt_um_asiclab_sum_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic       ena;
  int         n_chk  = 0;
  int         n_fail = 0;

  tt_um_asiclab_sum_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .ena     (ena),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a frame and check every clock of it. ebits[b] is the expected txd
  // level during bit-time b. mode 0: start pulsed; 1: start held high;
  // 2: start re-raised mid-frame with different operands.
  // Returns right after the edge that raises done.
  task automatic frame(input logic [7:0] ui, input logic [3:0] div,
                       input logic [4:0] esum, input logic [7:0] ebits, input int mode);
    ui_in  = ui;
    uio_in = {div, 3'b000, 1'b1};
    tick();
    if (mode != 1) uio_in[0] = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c <= int'(div); c++) begin
        chk("txd",  {7'b0, uo_out[0]}, {7'b0, ebits[b]});
        chk("busy", {7'b0, uo_out[1]}, 8'd1);
        chk("done", {7'b0, uo_out[2]}, 8'd0);
        chk("sum",  {3'b0, uo_out[7:3]}, {3'b0, esum});
        if (mode == 2 && b == 3 && c == 0) begin
          ui_in     = 8'h11;
          uio_in[0] = 1'b1;
        end
        tick();
      end
    end
    chk("done_end", {7'b0, uo_out[2]}, 8'd1);
    chk("busy_end", {7'b0, uo_out[1]}, 8'd0);
    chk("txd_end",  {7'b0, uo_out[0]}, 8'd1);
    chk("sum_end",  {3'b0, uo_out[7:3]}, {3'b0, esum});
  endtask

  initial begin
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    tick(); tick();
    chk("rst_uo",     uo_out,  8'h01);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe",  uio_oe,  8'h00);
    rst_n = 1'b1;
    tick();
    chk("idle_uo", uo_out, 8'h01);

    // 9+8=17 -> 0,1,0,0,0,1,0,1 at one clock per bit
    frame(8'h98, 4'd0, 5'd17, 8'b1010_0010, 0);
    tick();
    chk("done_pulse_len", {7'b0, uo_out[2]}, 8'd0);
    chk("idle_after",     uo_out, {5'd17, 3'b001});

    // 15+15=30, parity 0, 4 clocks/bit; then back-to-back 1+0 at 16 clocks/bit
    frame(8'hFF, 4'd3, 5'd30, 8'b1011_1100, 0);
    frame(8'h10, 4'd15, 5'd1, 8'b1100_0010, 0);
    tick();
    chk("b2b_done_low", {7'b0, uo_out[2]}, 8'd0);

    // start held high: one frame only
    frame(8'h23, 4'd1, 5'd5, 8'b1000_1010, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_idle", uo_out, {5'd5, 3'b001});
    end
    uio_in[0] = 1'b0;
    tick();

    // second start edge mid-frame is ignored
    frame(8'h98, 4'd0, 5'd17, 8'b1010_0010, 2);
    tick();
    chk("ignored_start_sum", uo_out, {5'd17, 3'b001});
    uio_in[0] = 1'b0;
    tick();

    // reset during DATA bit 2 (DIV=3: 4 START clocks + 8 for bits 0,1)
    ui_in  = 8'h98;
    uio_in = {4'd3, 3'b000, 1'b1};
    tick();
    uio_in[0] = 1'b0;
    repeat (12) tick();
    chk("pre_rst_txd",  {7'b0, uo_out[0]}, 8'd0);
    chk("pre_rst_busy", {7'b0, uo_out[1]}, 8'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_uo", uo_out, 8'h01);
    uio_in[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_no_done", uo_out, 8'h01);
    end
    rst_n = 1'b1;
    // start already high at release counts as an edge
    frame(8'h98, 4'd3, 5'd17, 8'b1010_0010, 0);
    tick();
    chk("final_idle", uo_out, {5'd17, 3'b001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
